// File: rtl/aes.sv
// AES-128 encryption core: one round per clock, round keys expanded on the fly.
// en loads a new block (state ^ key); done flags the ciphertext in state_out.
module aes (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [127:0] key,
  input  logic [127:0] state,
  output logic [127:0] state_out,
  output logic         done
);

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         done_q, done_d;

  logic [7:0]   rcon;
  logic [31:0]  rot_word, temp_word;
  logic [31:0]  nk0, nk1, nk2, nk3;
  logic [127:0] next_key;
  logic [127:0] sub_bytes, shift_rows, mix_cols, round_out;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    unique case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // RotWord moves byte 0 (the LSB) to the top of the word.
  always_comb begin
    rot_word  = {rkey_q[103:96], rkey_q[127:104]};
    temp_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                 sbox(rot_word[15:8]), sbox(rot_word[7:0])} ^ {24'h0, rcon};
    nk0       = rkey_q[31:0] ^ temp_word;
    nk1       = rkey_q[63:32] ^ nk0;
    nk2       = rkey_q[95:64] ^ nk1;
    nk3       = rkey_q[127:96] ^ nk2;
    next_key  = {nk3, nk2, nk1, nk0};
  end

  always_comb begin
    sub_bytes  = '0;
    shift_rows = '0;
    for (int i = 0; i < 16; i++) begin
      sub_bytes[8*i +: 8] = sbox(state_q[8*i +: 8]);
    end
    // Row r of column c takes the byte from column (c + r) mod 4.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_rows[8*(4*c+r) +: 8] = sub_bytes[8*(4*((c+r)%4)+r) +: 8];
      end
    end
  end

  always_comb begin
    mix_cols = '0;
    a0 = '0;
    a1 = '0;
    a2 = '0;
    a3 = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = shift_rows[32*c    +: 8];
      a1 = shift_rows[32*c+8  +: 8];
      a2 = shift_rows[32*c+16 +: 8];
      a3 = shift_rows[32*c+24 +: 8];
      mix_cols[32*c    +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mix_cols[32*c+8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mix_cols[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mix_cols[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    round_out = ((rnd_q == 4'd10) ? shift_rows : mix_cols) ^ next_key;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= '0;
      rkey_q  <= '0;
      rnd_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rkey_q  <= rkey_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  // rnd: 0 idle, 1..10 running, 11 finished; idle and finished hold all state.
  always_comb begin
    state_d = state_q;
    rkey_d  = rkey_q;
    rnd_d   = rnd_q;
    done_d  = done_q;
    if (en) begin
      state_d = state ^ key;
      rkey_d  = key;
      rnd_d   = 4'd1;
      done_d  = 1'b0;
    end else if (rnd_q >= 4'd1 && rnd_q <= 4'd10) begin
      state_d = round_out;
      rkey_d  = next_key;
      rnd_d   = rnd_q + 4'd1;
      done_d  = (rnd_q == 4'd10);
    end
  end

  always_comb begin
    state_out = state_q;
    done      = done_q;
  end

endmodule

// File: tb/tb_aes.sv
// Self-checking bench for the AES-128 core: known-answer vectors through a
// scoreboard queue, plus timing, restart, reset and hold-load scenarios.
module tb_aes;

  localparam logic [127:0] KeyC1 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] PtC1  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] CtC1  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
  localparam logic [127:0] Rnd1C1 = 128'he48f12cbd843182d68ce5a85e810d889;
  localparam logic [127:0] KeyB  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] PtB   = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] CtB   = 128'h320b6a19978511dcfb09dc021d842539;
  localparam logic [127:0] CtZero = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

  logic         clk;
  logic         rst;
  logic         en;
  logic [127:0] key_in;
  logic [127:0] pt_in;
  logic [127:0] state_out;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] last_ct;
  logic [127:0] hk, hp;

  aes dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .key       (key_in),
    .state     (pt_in),
    .state_out (state_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [127:0] k, input logic [127:0] p, input logic [127:0] ct);
    @(negedge clk);
    en     = 1'b1;
    key_in = k;
    pt_in  = p;
    @(negedge clk);
    en = 1'b0;
    exp_q.push_back(ct);
    check_eq("load_xor", state_out, p ^ k);
    check_eq("load_done", {127'b0, done}, 128'd0);
  endtask

  // Runs round edges first..10; done must rise exactly on edge 10.
  task automatic run_rounds(input int first);
    for (int i = first; i <= 10; i++) begin
      @(negedge clk);
      if (i < 10) begin
        check_eq("done_early", {127'b0, done}, 128'd0);
      end else begin
        check_eq("done_edge10", {127'b0, done}, 128'd1);
        check_eq("sb_depth", 128'(exp_q.size()), 128'd1);
        if (exp_q.size() > 0) begin
          last_ct = exp_q.pop_front();
          check_eq("ciphertext", state_out, last_ct);
        end
      end
    end
  endtask

  task automatic hold_check(input int edges);
    for (int i = 0; i < edges; i++) begin
      @(negedge clk);
      check_eq("hold_ct", state_out, last_ct);
      check_eq("hold_done", {127'b0, done}, 128'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst    = 1'b0;
    en     = 1'b0;
    key_in = '0;
    pt_in  = '0;
    last_ct = '0;
    #1;
    check_eq("reset_state", state_out, 128'd0);
    check_eq("reset_done", {127'b0, done}, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_state", state_out, 128'd0);
    check_eq("idle_done", {127'b0, done}, 128'd0);

    // FIPS C.1 with an intermediate round check, then a long idle hold
    do_load(KeyC1, PtC1, CtC1);
    @(negedge clk);
    check_eq("c1_round1", state_out, Rnd1C1);
    check_eq("c1_round1_done", {127'b0, done}, 128'd0);
    run_rounds(2);
    hold_check(40);

    do_load(KeyB, PtB, CtB);
    run_rounds(1);

    do_load('0, '0, CtZero);
    run_rounds(1);

    // Restart mid-computation: C.1 result is abandoned
    do_load(KeyC1, PtC1, CtC1);
    repeat (4) @(negedge clk);
    exp_q.delete();
    do_load(KeyB, PtB, CtB);
    run_rounds(1);
    hold_check(3);

    // Asynchronous reset mid-computation
    do_load(KeyB, PtB, CtB);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_async_state", state_out, 128'd0);
    check_eq("rst_async_done", {127'b0, done}, 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_state", state_out, 128'd0);
      check_eq("post_rst_done", {127'b0, done}, 128'd0);
    end

    // Hold-load: en high for 5 edges, only the last sampled inputs count
    @(negedge clk);
    en     = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    pt_in  = {$urandom, $urandom, $urandom, $urandom};
    hk = key_in;
    hp = pt_in;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check_eq("hold_reload", state_out, hp ^ hk);
      check_eq("hold_reload_done", {127'b0, done}, 128'd0);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      pt_in  = {$urandom, $urandom, $urandom, $urandom};
      hk = key_in;
      hp = pt_in;
    end
    do_load(KeyC1, PtC1, CtC1);
    run_rounds(1);
    hold_check(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes.md
AES -- requirements
Module: aes

Interface
REQ-001 The block SHALL have no parameters; the cipher is fixed to AES-128 encryption, 10 rounds.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: load/start; high = capture inputs, low = run/hold.
REQ-005 The block SHALL have port key, input, 128 bits: cipher key, sampled only on a load edge.
REQ-006 The block SHALL have port state, input, 128 bits: plaintext block, sampled only on a load edge.
REQ-007 The block SHALL have port state_out, output, 128 bits: the internal state register; it is the ciphertext when done=1.
REQ-008 The block SHALL have port done, output, 1 bit: high when state_out holds the final ciphertext.
REQ-009 Byte k (0..15) of the FIPS-197 byte sequence SHALL map to bits [8k+7:8k] of both state and key (byte 0 at the LSB).
REQ-010 State element s(r,c) SHALL be byte 4c+r, so columns are 32-bit words with word c = bits [32c+31:32c].

Function
REQ-011 The block SHALL hold four registers: a 128-bit state register, a 128-bit round-key register, a 4-bit round counter rnd, and done.
REQ-012 A rising edge with en=1 SHALL load state XOR key into the state register, load key into the round-key register, set rnd=1 and clear done.
REQ-013 A rising edge with en=1 SHALL also restart any computation in progress.
REQ-014 On a rising edge with en=0 and 1<=rnd<=10, the block SHALL compute the next round key combinationally from the round-key register, using FIPS-197 KeyExpansion with Rcon[rnd] = 01,02,04,08,10,20,40,80,1b,36.
REQ-015 The block SHALL store that next round key in the round-key register.
REQ-016 On the same edge, the state register SHALL load SubBytes -> ShiftRows -> MixColumns -> AddRoundKey(next key).
REQ-017 MixColumns SHALL be omitted when rnd=10.
REQ-018 On that same edge, rnd SHALL increment.
REQ-019 On the edge where rnd=10 is processed, done SHALL be set to 1 and rnd SHALL go to 11 (finished).
REQ-020 The block SHALL have three states: idle (rnd=0), running (rnd 1..10) and finished (rnd=11).
REQ-021 While in idle or finished with en=0, no register SHALL change, so state_out and done hold indefinitely.
REQ-022 Latency SHALL be 10 clock edges with en=0 after the load edge, one round per cycle; done=1 is visible after the 10th edge.
REQ-023 If en stays high, the block SHALL reload every edge and make no progress.
REQ-024 SubBytes SHALL use the FIPS-197 forward S-box, realised as 16 state lookups plus 4 key-schedule lookups per cycle, combinational ROM or equivalent.
REQ-025 MixColumns SHALL use GF(2^8) with polynomial x^8+x^4+x^3+x+1, where xtime = (b<<1) XOR (b[7] ? 8'h1b : 0).
REQ-026 ShiftRows SHALL rotate row r left by r columns under the REQ-010 mapping.
REQ-027 Mid-computation, state_out SHALL expose intermediate round states, and done SHALL stay 0 until completion.

Reset
REQ-028 While rst=0, and immediately without waiting for a clock, the block SHALL set state register=0, round-key register=0, rnd=0 (idle) and done=0, so state_out=0.
REQ-029 The block SHALL leave reset into idle.
REQ-030 Reset asserted mid-operation SHALL abort the computation; a new en=1 edge is required after release.

Verification
REQ-031 FIPS C.1 (key=128'h0f0e0d0c0b0a09080706050403020100, state=128'hffeeddccbbaa99887766554433221100): pulse en for one edge, then 10 edges -> state_out=128'h5ac5b47080b7cdd830047b6ad8e0c469, done=1.
REQ-032 FIPS B (key=128'h3c4fcf098815f7aba6d2ae2816157e2b, state=128'h340737e0a29831318d305a88a8f64332) -> state_out=128'h320b6a19978511dcfb09dc021d842539 after 10 edges.
REQ-033 Timing check: done=0 after each of edges 1..9 following the load, done=1 after edge 10, and outputs stable for 40 further idle edges.
REQ-034 Restart: assert en at round 5 with the B vectors, then release -> B ciphertext exactly 10 edges after the new load.
REQ-035 Reset: drop rst at round 6 -> state_out=0 and done=0 with no clock edge; after release and en low, outputs stay 0.
REQ-036 Hold-load: keep en=1 for 5 edges, then run -> correct ciphertext 10 edges after the last en=1 edge, with inputs changed during the hold using the final sampled values.
